branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the myCPU fetch stage: a direct-mapped, tagged branch target buffer with per-entry saturating direction counters. Fetch looks up the current PC and gets a registered taken/target prediction one cycle later; decode returns the actual outcome (same 3-bit branch kind encoding the branch unit uses) to train the table. A registered mispredict/redirect pair is produced for the PC mux.

---
 rtl/bp_pkg.sv | 44 ++++
 rtl/bp_sat_counter.sv | 25 ++
 rtl/branch_predictor.sv | 146 ++++++++++++++
 tb/tb_branch_predictor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg -- shared definitions for the branch predictor slice.
//   * Branch-kind codes carried on upd_kind (same encoding as the branch unit).
//   * PC -> table index / tag extraction helpers (parametrised by field widths).
//   * Direction-counter initial values used on allocation.
package bp_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;
  localparam logic [2:0] BR_JUMP = 3'b111;

  // Word-aligned PC: index starts at bit 2.
  function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                           input int unsigned index_bits);
    logic [31:0] mask;
    mask = (32'd1 << index_bits) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  // Tag sits directly above the index field. A 32-bit-wide tag wraps the
  // mask computation to all ones, which is the intended result.
  function automatic logic [31:0] bp_tag(input logic [31:0] pc,
                                         input int unsigned index_bits,
                                         input int unsigned tag_bits);
    logic [31:0] mask;
    mask = (32'd1 << tag_bits) - 32'd1;
    return (pc >> (index_bits + 2)) & mask;
  endfunction

  // Weakly taken: only the MSB set.
  function automatic logic [31:0] bp_cnt_weak_taken(input int unsigned cnt_bits);
    return 32'd1 << (cnt_bits - 1);
  endfunction

  // Strongly taken: all ones (used for unconditional jumps).
  function automatic logic [31:0] bp_cnt_all_ones(input int unsigned cnt_bits);
    return (32'd1 << cnt_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter -- combinational next value of a CNT_BITS-wide saturating
// up/down counter. Stays at max on increment and at 0 on decrement.
//   i_cnt  : current counter value
//   i_inc  : 1 = count up (branch taken), 0 = count down (not taken)
//   o_next : saturated next value
module bp_sat_counter #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] i_cnt,
  input  logic                i_inc,
  output logic [CNT_BITS-1:0] o_next
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  always_comb begin
    o_next = i_cnt;
    if (i_inc) begin
      if (i_cnt != CNT_MAX) o_next = i_cnt + CNT_BITS'(1);
    end else begin
      if (i_cnt != '0) o_next = i_cnt - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor -- direct-mapped tagged BTB with per-entry saturating
// direction counters for the fetch stage.
//   clk, rst                  : clock, synchronous active-high reset
//   lookup_en, lookup_pc      : fetch-side lookup request
//   pred_valid/taken/target   : registered prediction, one cycle after lookup
//   upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
//   upd_pred_taken, upd_pred_target : resolved-branch training interface
//   mispredict, redirect_pc   : registered redirect request for the PC mux
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int CNT_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [2:0]  upd_kind,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(bp_cnt_weak_taken(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_ONES = CNT_BITS'(bp_cnt_all_ones(CNT_BITS));

  // Table storage: valid/counter are control and get cleared; tag, target
  // and uncond are only meaningful while valid is set.
  logic                r_valid  [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
  logic                r_uncond [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];

  logic                r_vld_p1;
  logic                r_pred_taken_p1;
  logic [31:0]         r_pred_target_p1;
  logic                r_mispredict_p1;
  logic [31:0]         r_redirect_pc_p1;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;
  logic                  w_lk_taken;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_go;
  logic                  w_upd_hit;
  logic                  w_upd_jump;
  logic [CNT_BITS-1:0]   w_cnt_next;
  logic                  w_mis;
  logic [31:0]           w_redirect;

  // ---- stage p0: table read (lookup) and update decode ----
  assign w_lk_idx   = INDEX_BITS'(bp_index(lookup_pc, INDEX_BITS));
  assign w_lk_tag   = TAG_BITS'(bp_tag(lookup_pc, INDEX_BITS, TAG_BITS));
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && (r_uncond[w_lk_idx] || r_cnt[w_lk_idx][CNT_BITS-1]);

  assign w_upd_idx  = INDEX_BITS'(bp_index(upd_pc, INDEX_BITS));
  assign w_upd_tag  = TAG_BITS'(bp_tag(upd_pc, INDEX_BITS, TAG_BITS));
  assign w_upd_go   = upd_valid && (upd_kind != BR_NONE);
  assign w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_jump = (upd_kind == BR_JUMP);

  bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
    .i_cnt  (r_cnt[w_upd_idx]),
    .i_inc  (upd_taken),
    .o_next (w_cnt_next)
  );

  assign w_mis = (upd_pred_taken != upd_taken) ||
                 (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));
  // Not-taken resumes after the delay slot, which fetch already has.
  assign w_redirect = upd_taken ? upd_target : (upd_pc + 32'd8);

  // Control half of the table. Reads above see pre-update contents, which
  // gives read-before-write for a same-index lookup and update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= '0;
      end
    end else if (w_upd_go) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= w_cnt_next;
      end else if (upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_cnt[w_upd_idx]   <= w_upd_jump ? CNT_ONES : CNT_WEAK;
      end
    end
  end

  // Data half of the table; rst still blocks the write so a reset-cycle
  // update leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && w_upd_go) begin
      if (w_upd_hit) begin
        r_uncond[w_upd_idx] <= w_upd_jump;
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        r_uncond[w_upd_idx] <= w_upd_jump;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
      end
    end
  end

  // ---- stage p1: registered prediction and redirect ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1         <= 1'b0;
      r_pred_taken_p1  <= 1'b0;
      r_pred_target_p1 <= '0;
      r_mispredict_p1  <= 1'b0;
      r_redirect_pc_p1 <= '0;
    end else begin
      r_vld_p1 <= lookup_en;
      if (lookup_en) begin
        r_pred_taken_p1  <= w_lk_taken;
        r_pred_target_p1 <= w_lk_taken ? r_target[w_lk_idx] : 32'd0;
      end
      r_mispredict_p1 <= w_upd_go && w_mis;
      if (w_upd_go && w_mis) r_redirect_pc_p1 <= w_redirect;
    end
  end

  assign pred_valid  = r_vld_p1;
  assign pred_taken  = r_pred_taken_p1;
  assign pred_target = r_pred_target_p1;
  assign mispredict  = r_mispredict_p1;
  assign redirect_pc = r_redirect_pc_p1;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor -- directed stimulus with a spec-level reference model
// and per-cycle output comparison, plus hand-computed literal expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8), .CNT_BITS(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_en       (lookup_en),
    .lookup_pc       (lookup_pc),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_kind        (upd_kind),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    int        tagv;
    bit        unc;
    int        cnt;
    bit [31:0] tgt;
  } ent_t;

  ent_t      tbl [64];
  bit        e_pv  = 0;
  bit        e_pt  = 0;
  bit [31:0] e_ptg = 0;
  bit        e_mp  = 0;
  bit [31:0] e_rpc = 0;

  function automatic int m_idx(input bit [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int m_tag(input bit [31:0] pc);
    return int'((pc / 256) % 256);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        tbl[i].v   = 0;
        tbl[i].cnt = 0;
      end
      e_pv = 0; e_pt = 0; e_ptg = 0; e_mp = 0; e_rpc = 0;
    end else begin
      int  li, ui;
      bit  hit, go, wrong;
      e_pv = lookup_en;
      if (lookup_en) begin
        li   = m_idx(lookup_pc);
        hit  = tbl[li].v && tbl[li].tagv == m_tag(lookup_pc);
        e_pt = hit && (tbl[li].unc || tbl[li].cnt >= 2);
        e_ptg = e_pt ? tbl[li].tgt : 32'd0;
      end
      go    = upd_valid && upd_kind != 3'd0;
      wrong = (upd_pred_taken != upd_taken) ||
              (upd_taken && upd_pred_taken && upd_pred_target != upd_target);
      e_mp = go && wrong;
      if (e_mp) e_rpc = upd_taken ? upd_target : upd_pc + 32'd8;
      if (go) begin
        ui  = m_idx(upd_pc);
        hit = tbl[ui].v && tbl[ui].tagv == m_tag(upd_pc);
        if (hit) begin
          tbl[ui].cnt = upd_taken ? ((tbl[ui].cnt == 3) ? 3 : tbl[ui].cnt + 1)
                                  : ((tbl[ui].cnt == 0) ? 0 : tbl[ui].cnt - 1);
          if (upd_taken) tbl[ui].tgt = upd_target;
          tbl[ui].unc = (upd_kind == 3'd7);
        end else if (upd_taken) begin
          tbl[ui].v    = 1;
          tbl[ui].tagv = m_tag(upd_pc);
          tbl[ui].tgt  = upd_target;
          tbl[ui].unc  = (upd_kind == 3'd7);
          tbl[ui].cnt  = (upd_kind == 3'd7) ? 3 : 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    checks++;
    if (pred_valid !== e_pv) begin
      errors++;
      $display("FAIL model.pred_valid: got %b want %b at %0t", pred_valid, e_pv, $time);
    end
    checks++;
    if (pred_taken !== e_pt) begin
      errors++;
      $display("FAIL model.pred_taken: got %b want %b at %0t", pred_taken, e_pt, $time);
    end
    checks++;
    if (pred_target !== e_ptg) begin
      errors++;
      $display("FAIL model.pred_target: got %h want %h at %0t", pred_target, e_ptg, $time);
    end
    checks++;
    if (mispredict !== e_mp) begin
      errors++;
      $display("FAIL model.mispredict: got %b want %b at %0t", mispredict, e_mp, $time);
    end
    checks++;
    if (redirect_pc !== e_rpc) begin
      errors++;
      $display("FAIL model.redirect_pc: got %h want %h at %0t", redirect_pc, e_rpc, $time);
    end
  end

  // ---------------- literal checks and stimulus ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic le, input logic [31:0] lpc,
                     input logic uv, input logic [31:0] upc, input logic [2:0] k,
                     input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg);
    lookup_en       = le;
    lookup_pc       = lpc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_kind        = k;
    upd_taken       = tk;
    upd_target      = tg;
    upd_pred_taken  = ptk;
    upd_pred_target = ptg;
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1'b1, pc, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [2:0] k, input logic tk,
                     input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    cyc(1'b0, 32'd0, 1'b1, pc, k, tk, tg, ptk, ptg);
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    lookup_en = 0; lookup_pc = 0; upd_valid = 0; upd_pc = 0; upd_kind = 0;
    upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    idle();
    idle();
    lit("reset.pred_valid", 32'(pred_valid), 32'd0);
    lit("reset.mispredict", 32'(mispredict), 32'd0);
    lit("reset.redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;

    // Cold lookup misses.
    look(32'hBFC00000);
    lit("cold.pred_valid", 32'(pred_valid), 32'd1);
    lit("cold.pred_taken", 32'(pred_taken), 32'd0);
    lit("cold.pred_target", pred_target, 32'd0);

    // Allocate a taken beq.
    upd(32'hBFC00010, 3'd1, 1'b1, 32'hBFC00040, 1'b0, 32'd0);
    lit("alloc.mispredict", 32'(mispredict), 32'd1);
    lit("alloc.redirect_pc", redirect_pc, 32'hBFC00040);
    look(32'hBFC00010);
    lit("alloc_hit.pred_taken", 32'(pred_taken), 32'd1);
    lit("alloc_hit.pred_target", pred_target, 32'hBFC00040);
    lit("alloc_hit.mispredict", 32'(mispredict), 32'd0);

    // Train down to 0 and beyond; predicted-taken not-taken redirects to pc+8.
    upd(32'hBFC00010, 3'd1, 1'b0, 32'd0, 1'b1, 32'hBFC00040);
    lit("nt1.redirect_pc", redirect_pc, 32'hBFC00018);
    upd(32'hBFC00010, 3'd1, 1'b0, 32'd0, 1'b0, 32'd0);
    upd(32'hBFC00010, 3'd1, 1'b0, 32'd0, 1'b0, 32'd0);
    look(32'hBFC00010);
    lit("sat0.pred_taken", 32'(pred_taken), 32'd0);
    upd(32'hBFC00010, 3'd1, 1'b0, 32'd0, 1'b0, 32'd0);
    upd(32'hBFC00010, 3'd1, 1'b1, 32'hBFC00040, 1'b0, 32'd0);
    look(32'hBFC00010);
    lit("cnt1.pred_taken", 32'(pred_taken), 32'd0);
    lit("cnt1.pred_target", pred_target, 32'd0);

    // Unconditional jump.
    upd(32'h80000100, 3'd7, 1'b1, 32'h80002000, 1'b0, 32'd0);
    lit("jump.redirect_pc", redirect_pc, 32'h80002000);
    look(32'h80000100);
    lit("jump.pred_taken", 32'(pred_taken), 32'd1);
    lit("jump.pred_target", pred_target, 32'h80002000);
    idle();
    lit("hold.pred_valid", 32'(pred_valid), 32'd0);
    lit("hold.pred_target", pred_target, 32'h80002000);
    look(32'h80000100);
    lit("jump2.pred_taken", 32'(pred_taken), 32'd1);

    // Correctly predicted not-taken beq: no redirect, redirect_pc holds.
    upd(32'h80000200, 3'd1, 1'b0, 32'd0, 1'b0, 32'd0);
    lit("ok_nt.mispredict", 32'(mispredict), 32'd0);
    lit("ok_nt.redirect_pc", redirect_pc, 32'h80002000);

    // Both taken, wrong predicted target.
    upd(32'h80000100, 3'd7, 1'b1, 32'h80002000, 1'b1, 32'h80003000);
    lit("tgt_mis.mispredict", 32'(mispredict), 32'd1);

    // Kind none never redirects or trains.
    upd(32'h80000300, 3'd0, 1'b1, 32'h80000400, 1'b0, 32'd0);
    lit("none.mispredict", 32'(mispredict), 32'd0);
    look(32'h80000300);
    lit("none.pred_taken", 32'(pred_taken), 32'd0);

    // pc+8 wraps modulo 2^32.
    upd(32'hFFFFFFFC, 3'd1, 1'b0, 32'd0, 1'b1, 32'h00000100);
    lit("wrap.redirect_pc", redirect_pc, 32'h00000004);

    // Aliasing: same index, different tag.
    upd(32'h80000020, 3'd1, 1'b1, 32'h80000800, 1'b0, 32'd0);
    look(32'h80000020);
    lit("alias1.pred_target", pred_target, 32'h80000800);
    upd(32'h80000120, 3'd2, 1'b1, 32'h80000900, 1'b0, 32'd0);
    look(32'h80000020);
    lit("alias_evict.pred_taken", 32'(pred_taken), 32'd0);
    look(32'h80000120);
    lit("alias2.pred_target", pred_target, 32'h80000900);

    // Same-cycle lookup and allocating update: read-before-write.
    cyc(1'b1, 32'h80000030, 1'b1, 32'h80000030, 3'd3, 1'b1, 32'h80000A00, 1'b0, 32'd0);
    lit("rbw.pred_valid", 32'(pred_valid), 32'd1);
    lit("rbw.pred_taken", 32'(pred_taken), 32'd0);
    look(32'h80000030);
    lit("rbw_next.pred_target", pred_target, 32'h80000A00);

    // Reset during an update and a lookup.
    rst = 1'b1;
    cyc(1'b1, 32'h80000040, 1'b1, 32'h80000040, 3'd1, 1'b1, 32'h80000B00, 1'b0, 32'd0);
    lit("rst_mid.pred_valid", 32'(pred_valid), 32'd0);
    lit("rst_mid.mispredict", 32'(mispredict), 32'd0);
    lit("rst_mid.redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    look(32'h80000040);
    lit("rst_discard.pred_taken", 32'(pred_taken), 32'd0);
    look(32'h80000100);
    lit("rst_clear.pred_taken", 32'(pred_taken), 32'd0);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
